// File: rtl/riscv_instr_mem_responder.sv
// Instruction-memory responder for the core fetch port: word-addressed SRAM with a
// fixed-latency, in-order read pipe, grant throttling by outstanding count, and a loader write port.
module riscv_instr_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_OUT   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ERR_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        stall_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [3:0]  wr_be_i,
  input  logic [31:0] wr_data_i,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [31:0]       mem_q [DEPTH];
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic              busy_q;
  logic [RD_LAT-1:0] vld_q, err_q;
  logic [31:0]       dat_q [RD_LAT];

  logic              gnt_c, rvalid_c;
  logic [31:0]       rd_off_c, wr_off_c, rd_word_c;
  logic              rd_oor_c, wr_oor_c;
  logic [AW-1:0]     rd_idx_c, wr_idx_c;
  logic [RD_LAT-1:0] vld_in_c, err_in_c;
  logic [31:0]       dat_in_c [RD_LAT];

  assign rvalid_c = vld_q[RD_LAT-1];

  // Address decode; the unsigned offset wraps for addresses below BASE_ADDR, so one compare covers both sides
  always_comb begin
    rd_off_c  = instr_addr_i - BASE_ADDR;
    wr_off_c  = wr_addr_i - BASE_ADDR;
    rd_oor_c  = (rd_off_c >> (AW + 2)) != 32'd0;
    wr_oor_c  = (wr_off_c >> (AW + 2)) != 32'd0;
    rd_idx_c  = rd_off_c[AW+1:2];
    wr_idx_c  = wr_off_c[AW+1:2];
    rd_word_c = rd_oor_c ? ERR_WORD : mem_q[rd_idx_c];
  end

  // A full window can still grant when a response retires in the same cycle
  always_comb begin
    gnt_c = instr_req_i & ~stall_i &
            ((out_cnt_q < CW'(MAX_OUT)) | ((out_cnt_q == CW'(MAX_OUT)) & rvalid_c));
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (gnt_c && !rvalid_c) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end else if (!gnt_c && rvalid_c) begin
      out_cnt_d = out_cnt_q - CW'(1);
    end
  end

  // Stage inputs: stage 0 takes the fresh read, later stages shift from their predecessor
  always_comb begin
    vld_in_c    = '0;
    err_in_c    = '0;
    dat_in_c    = '{default: '0};
    vld_in_c[0] = gnt_c;
    err_in_c[0] = rd_oor_c;
    dat_in_c[0] = rd_word_c;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_in_c[i] = vld_q[i-1];
      err_in_c[i] = err_q[i-1];
      dat_in_c[i] = dat_q[i-1];
    end
  end

  // Data/err stages load only with a valid token so the output holds between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
      busy_q    <= 1'b0;
      vld_q     <= '0;
      err_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      out_cnt_q <= out_cnt_d;
      busy_q    <= out_cnt_d != '0;
      vld_q     <= vld_in_c;
      for (int i = 0; i < RD_LAT; i++) begin
        if (vld_in_c[i]) begin
          dat_q[i] <= dat_in_c[i];
          err_q[i] <= err_in_c[i];
        end
      end
    end
  end

  // Storage is not reset; reads see pre-write contents on a same-edge collision
  always_ff @(posedge clk) begin
    if (wr_en_i && !wr_oor_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) begin
          mem_q[wr_idx_c][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  assign instr_gnt_o    = gnt_c;
  assign instr_rvalid_o = rvalid_c;
  assign instr_rdata_o  = dat_q[RD_LAT-1];
  assign instr_err_o    = err_q[RD_LAT-1];
  assign busy_o         = busy_q;

  a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n) gnt_c |-> instr_req_i);
  a_cnt_bound:     assert property (@(posedge clk) disable iff (!rst_n) out_cnt_q <= CW'(MAX_OUT));
  a_no_underflow:  assert property (@(posedge clk) disable iff (!rst_n) rvalid_c |-> out_cnt_q != '0);
  a_fixed_lat:     assert property (@(posedge clk) disable iff (!rst_n) rvalid_c |-> $past(gnt_c, RD_LAT));

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Bench for riscv_instr_mem_responder: RD_LAT=1 instance with a grant/response scoreboard,
// plus an RD_LAT=3 instance for window throttling and mid-flight reset.
module tb_riscv_instr_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AWB   = 6;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] ERRW  = 32'hBAD0_BAD0;
  localparam logic [31:0] BASE3 = 32'h0000_1000;
  localparam logic [31:0] ERRW3 = 32'hE3E3_E3E3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, stall, wr_en, gnt, rvalid, err, busy;
  logic [31:0] addr, wr_addr, wr_data, rdata;
  logic [3:0]  wr_be;
  logic        req3, stall3, wr_en3, gnt3, rvalid3, err3, busy3;
  logic [31:0] addr3, wr_addr3, wr_data3, rdata3;
  logic [3:0]  wr_be3;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] gcyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model [DEPTH];
  logic [31:0] q3[$];

  riscv_instr_mem_responder #(
    .DEPTH(DEPTH), .RD_LAT(1), .MAX_OUT(2), .BASE_ADDR(BASE), .ERR_WORD(ERRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt),
    .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(err), .stall_i(stall),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data), .busy_o(busy)
  );

  riscv_instr_mem_responder #(
    .DEPTH(16), .RD_LAT(3), .MAX_OUT(2), .BASE_ADDR(BASE3), .ERR_WORD(ERRW3)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req3), .instr_addr_i(addr3), .instr_gnt_o(gnt3),
    .instr_rvalid_o(rvalid3), .instr_rdata_o(rdata3), .instr_err_o(err3), .stall_i(stall3),
    .wr_en_i(wr_en3), .wr_addr_i(wr_addr3), .wr_be_i(wr_be3), .wr_data_i(wr_data3), .busy_o(busy3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Scoreboard for the RD_LAT=1 instance: push on grant, pop and compare on rvalid
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_spurious: rvalid=1 with nothing outstanding, rdata=%h", rdata);
        end else begin
          mon_e = sb.pop_front();
          if (rdata !== mon_e.data || err !== mon_e.err || 32'(cyc) - mon_e.gcyc != 32'd1) begin
            errors++;
            $display("FAIL sb_resp: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=1",
                     rdata, err, 32'(cyc) - mon_e.gcyc, mon_e.data, mon_e.err);
          end
        end
      end
      if (gnt) begin
        if ((addr - BASE) >= DEPTH * 4) begin
          sb.push_back('{data: ERRW, err: 1'b1, gcyc: 32'(cyc)});
        end else begin
          sb.push_back('{data: model[addr[AWB+1:2]], err: 1'b0, gcyc: 32'(cyc)});
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] off;
    off = a - BASE;
    if (off < DEPTH * 4) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model[off[AWB+1:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    next_cycle();
    model_write(a, be, d);
    wr_en = 1'b0;
  endtask

  task automatic load3(input logic [31:0] a, input logic [31:0] d);
    wr_en3 = 1'b1; wr_addr3 = a; wr_be3 = 4'hF; wr_data3 = d;
    next_cycle();
    wr_en3 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b0; addr = '0; stall = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    req3 = 1'b0; addr3 = '0; stall3 = 1'b0; wr_en3 = 1'b0; wr_addr3 = '0; wr_be3 = '0; wr_data3 = '0;
    @(negedge clk);
    checks++;
    if ({gnt, rvalid, err, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: gnt/rvalid/err/busy=%b want 0000", {gnt, rvalid, err, busy});
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 00000000", rdata);
    end
    checks++;
    if ({gnt3, rvalid3, err3, busy3} !== 4'b0000 || rdata3 !== 32'h0) begin
      errors++; $display("FAIL reset_dut3: ctrl=%b rdata=%h want 0000/0", {gnt3, rvalid3, err3, busy3}, rdata3);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_preload();
    load(32'd0,  4'hF, 32'h11);
    load(32'd4,  4'hF, 32'h22);
    load(32'd8,  4'hF, 32'h33);
    load(32'd12, 4'hF, 32'h44);
    load(32'd20, 4'hF, 32'h1234_5678);
  endtask

  task automatic test_stream();
    logic [31:0] exp_d [4];
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; addr = 32'(4 * i);
      @(negedge clk);
      checks++;
      if (gnt !== 1'b1) begin
        errors++; $display("FAIL stream_gnt%0d: got %b want 1", i, gnt);
      end
      if (i > 0) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp_d[i-1]) begin
          errors++; $display("FAIL stream_rsp%0d: rvalid=%b rdata=%h want 1/%h", i - 1, rvalid, rdata, exp_d[i-1]);
        end
      end
      next_cycle();
    end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h44 || busy !== 1'b1) begin
      errors++; $display("FAIL stream_last: rvalid=%b rdata=%h busy=%b want 1/44/1", rvalid, rdata, busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || busy !== 1'b0 || rdata !== 32'h44) begin
      errors++; $display("FAIL stream_idle: rvalid=%b busy=%b rdata=%h want 0/0/44 held", rvalid, busy, rdata);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    stall = 1'b1; req = 1'b1; addr = 32'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 1'b0 || rvalid !== 1'b0) begin
        errors++; $display("FAIL stall_c%0d: gnt=%b rvalid=%b want 0/0", i, gnt, rvalid);
      end
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL stall_release_gnt: got %b want 1", gnt);
    end
    next_cycle();
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h33) begin
      errors++; $display("FAIL stall_rsp: rvalid=%b rdata=%h want 1/33", rvalid, rdata);
    end
    next_cycle();
  endtask

  task automatic test_write_collision();
    req = 1'b1; addr = 32'd20;
    wr_en = 1'b1; wr_addr = 32'd20; wr_be = 4'b0011; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL coll_gnt: got %b want 1", gnt);
    end
    next_cycle();
    model_write(32'd20, 4'b0011, 32'hDEAD_BEEF);
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL coll_old: rvalid=%b rdata=%h want 1/12345678", rvalid, rdata);
    end
    next_cycle();
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1234_BEEF) begin
      errors++; $display("FAIL coll_new: rvalid=%b rdata=%h want 1/1234BEEF", rvalid, rdata);
    end
    next_cycle();
  endtask

  task automatic test_out_of_range();
    load(DEPTH * 4, 4'hF, 32'hFFFF_FFFF);
    req = 1'b1; addr = DEPTH * 4;
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL oor_gnt: got %b want 1", gnt);
    end
    next_cycle();
    addr = 32'd0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== ERRW) begin
      errors++; $display("FAIL oor_rsp: rvalid=%b err=%b rdata=%h want 1/1/%h", rvalid, err, rdata, ERRW);
    end
    next_cycle();
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h11) begin
      errors++; $display("FAIL oor_wr_dropped: rvalid=%b err=%b rdata=%h want 1/0/11", rvalid, err, rdata);
    end
    next_cycle();
  endtask

  task automatic test_window();
    int g = 0, gnts = 0, rvs = 0;
    logic exp_g, exp_rv;
    for (int k = 0; k < 4; k++) load3(BASE3 + 32'(4 * k), 32'hA0 + 32'(k));
    for (int i = 0; i < 12; i++) begin
      req3 = 1'b1; addr3 = BASE3 + 32'(4 * (g % 4));
      exp_g  = (i % 3) != 2;
      exp_rv = (i >= 3) && (((i - 3) % 3) != 2);
      @(negedge clk);
      checks++;
      if (gnt3 !== exp_g || rvalid3 !== exp_rv) begin
        errors++; $display("FAIL win_c%0d: gnt=%b rvalid=%b want %b/%b", i, gnt3, rvalid3, exp_g, exp_rv);
      end
      checks++;
      if (gnts - rvs > 2) begin
        errors++; $display("FAIL win_outstanding%0d: got %0d want <=2", i, gnts - rvs);
      end
      if (rvalid3) begin
        rvs++;
        checks++;
        if (q3.size() == 0 || rdata3 !== q3[0] || err3 !== 1'b0) begin
          errors++; $display("FAIL win_data%0d: rdata=%h err=%b want %h/0", i, rdata3, err3,
                             q3.size() != 0 ? q3[0] : 32'hX);
        end
        if (q3.size() != 0) void'(q3.pop_front());
      end
      if (gnt3) begin
        q3.push_back(32'hA0 + 32'(g % 4));
        g++;
        gnts++;
      end
      next_cycle();
    end
    req3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rvalid3) begin
        rvs++;
        checks++;
        if (q3.size() == 0 || rdata3 !== q3[0]) begin
          errors++; $display("FAIL win_drain%0d: rdata=%h", i, rdata3);
        end
        if (q3.size() != 0) void'(q3.pop_front());
      end
      next_cycle();
    end
    checks++;
    if (gnts != rvs || gnts != 8 || busy3 !== 1'b0) begin
      errors++; $display("FAIL win_totals: gnts=%0d rvalids=%0d busy=%b want 8/8/0", gnts, rvs, busy3);
    end
  endtask

  task automatic test_reset_midflight();
    req3 = 1'b1; addr3 = BASE3 + 32'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (gnt3 !== 1'b1) begin
        errors++; $display("FAIL mid_gnt%0d: got %b want 1", i, gnt3);
      end
      next_cycle();
    end
    req3 = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid3 !== 1'b0 || busy3 !== 1'b0) begin
        errors++; $display("FAIL mid_in_reset%0d: rvalid=%b busy=%b want 0/0", i, rvalid3, busy3);
      end
      next_cycle();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid3 !== 1'b0 || busy3 !== 1'b0) begin
        errors++; $display("FAIL mid_after%0d: rvalid=%b busy=%b want 0/0", i, rvalid3, busy3);
      end
      next_cycle();
    end
    req3 = 1'b1; addr3 = BASE3 + 32'd8;
    @(negedge clk);
    checks++;
    if (gnt3 !== 1'b1) begin
      errors++; $display("FAIL mid_new_gnt: got %b want 1", gnt3);
    end
    next_cycle();
    req3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid3 !== (i == 2) || (i == 2 && (rdata3 !== 32'hA2 || err3 !== 1'b0))) begin
        errors++; $display("FAIL mid_new_rsp%0d: rvalid=%b rdata=%h err=%b want %b/A2/0",
                           i, rvalid3, rdata3, err3, i == 2);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_stream();
    test_stall();
    test_write_collision();
    test_out_of_range();
    test_window();
    test_reset_midflight();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d responses never returned", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
